// File: rtl/add_share_ctrl_pkg.sv
// Shared types, defaults and the round-robin pick helper
// for the shared-adder controller.
package add_ctrl_pkg;

    localparam int NREQ_DEF = 4;
    localparam int IDW_DEF  = 2;
    localparam int W_DEF    = 32;
    localparam int NREQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    // First requester with valid set, searching upward from the one
    // after 'last' and wrapping at nreq. Returns 'last' when none is set.
    function automatic logic [2:0] rr_pick(
        input logic [NREQ_MAX-1:0] req,
        input logic [2:0]          last,
        input int unsigned         nreq
    );
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= NREQ_MAX; k++) begin
            idx = (32'(last) + k) % nreq;
            if (!found && (k <= nreq) && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/add_share_ctrl_if.sv
// Requester and response handshake bundle for the
// shared-adder controller.
interface add_share_ctrl_if #(
    parameter int NREQ = add_ctrl_pkg::NREQ_DEF,
    parameter int IDW  = add_ctrl_pkg::IDW_DEF,
    parameter int W    = add_ctrl_pkg::W_DEF
) ();

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;

    logic              resp_valid;
    logic              resp_ready;
    logic [W-1:0]      resp_data;
    logic [IDW-1:0]    resp_id;
    logic              resp_carry;
    logic              resp_ovf;

    // Requesters plus result consumer
    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_id,
        input  resp_carry,
        input  resp_ovf
    );

    // The arbitrating controller
    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_id,
        output resp_carry,
        output resp_ovf
    );

endinterface

// File: rtl/add_share_ctrl_add.sv
// Plain combinational W-bit adder used as the shared
// datapath; sum wraps modulo 2^W.
module ADD #(
    parameter int W = 32
) (
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    output logic [W-1:0] Result
);

    assign Result = in1 + in2;

endmodule

// File: rtl/add_share_ctrl.sv
// Round-robin controller sharing one ADD among NREQ
// requesters; returns a registered, ID-tagged sum.
module add_share_ctrl
    import add_ctrl_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = IDW_DEF,
    parameter int W    = W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    add_share_ctrl_if.slave   bus,
    output logic              busy,
    output logic [15:0]       ops_done
);

    state_e           state_q;
    logic [IDW-1:0]   last_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [IDW-1:0]   id_q;
    logic [W-1:0]     data_q;
    logic [IDW-1:0]   rid_q;
    logic             carry_q;
    logic             ovf_q;
    logic             rvalid_q;
    logic [15:0]      ops_q;

    logic [NREQ_MAX-1:0] req_pad;
    logic [2:0]          pick;
    logic [IDW-1:0]      grant_id;
    logic                any_req;
    logic [NREQ-1:0]     ready_c;

    logic [W-1:0]     sum_c;
    logic [W:0]       wide_c;
    logic             carry_c;
    logic             ovf_c;
    logic             unused_wide_lo;

    assign req_pad  = NREQ_MAX'(bus.req_valid);
    assign pick     = rr_pick(req_pad, 3'(last_q), NREQ);
    assign grant_id = IDW'(pick);
    assign any_req  = |bus.req_valid;

    // One-hot accept, only while idle and something is offered
    always_comb begin
        ready_c = '0;
        if ((state_q == IDLE) && any_req) begin
            ready_c[grant_id] = 1'b1;
        end
    end

    ADD #(
        .W(W)
    ) u_add (
        .in1   (a_q),
        .in2   (b_q),
        .Result(sum_c)
    );

    // Carry comes from a W+1-bit add beside the shared adder;
    // its low bits duplicate ADD's result and are not needed.
    assign wide_c         = {1'b0, a_q} + {1'b0, b_q};
    assign carry_c        = wide_c[W];
    assign unused_wide_lo = ^wide_c[W-1:0];
    assign ovf_c          = (a_q[W-1] == b_q[W-1])
                          & (sum_c[W-1] != a_q[W-1]);

    // Controller FSM: grant/latch, execute, hold the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= IDW'(NREQ - 1);
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            data_q   <= '0;
            rid_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            ops_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        a_q     <= bus.req_a[grant_id*W +: W];
                        b_q     <= bus.req_b[grant_id*W +: W];
                        id_q    <= grant_id;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    data_q   <= sum_c;
                    carry_q  <= carry_c;
                    ovf_q    <= ovf_c;
                    rid_q    <= id_q;
                    rvalid_q <= 1'b1;
                    state_q  <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        rvalid_q <= 1'b0;
                        last_q   <= rid_q;
                        ops_q    <= ops_q + 16'd1;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.resp_valid = rvalid_q;
    assign bus.resp_data  = data_q;
    assign bus.resp_id    = rid_q;
    assign bus.resp_carry = carry_q;
    assign bus.resp_ovf   = ovf_q;

    assign busy     = (state_q != IDLE);
    assign ops_done = ops_q;

endmodule

// File: tb/tb_add_share_ctrl.sv
// Scoreboard bench for add_share_ctrl: directed vectors,
// grant and response monitors pop expected queues.
module tb_add_share_ctrl;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 32;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
        logic           carry;
        logic           ovf;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] ops_done;

    add_share_ctrl_if #(.NREQ(NREQ), .IDW(IDW), .W(W)) bus ();

    add_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    n_grants = 0;
    int    grant_cyc = 0;
    int    prev_g = -1;
    bit    tput_on = 1'b0;
    bit    seen = 1'b0;
    resp_t exp_q[$];
    int    gnt_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Grant monitor
    always @(negedge clk) begin
        if (rst_n && (bus.req_ready != '0)) begin
            n_grants++;
            grant_cyc = cyc;
            chk("grant_onehot", 32'($onehot(bus.req_ready)), 32'd1);
            if (gnt_q.size() == 0)
                chk("grant_unexpected", 32'(bus.req_ready), 32'd0);
            else
                chk("grant_idx", 32'(bus.req_ready),
                    32'd1 << gnt_q.pop_front());
            if (tput_on) begin
                if (prev_g >= 0) chk("t2_tput", 32'(cyc - prev_g), 32'd3);
                prev_g = cyc;
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        resp_t e;
        if (bus.resp_valid) begin
            if (!seen) begin
                chk("latency", 32'(cyc - grant_cyc), 32'd2);
                seen = 1'b1;
            end
            if (bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_id", 32'(bus.resp_id), 32'(e.id));
                    chk("resp_data", bus.resp_data, e.data);
                    chk("resp_carry", 32'(bus.resp_carry), 32'(e.carry));
                    chk("resp_ovf", 32'(bus.resp_ovf), 32'(e.ovf));
                end
            end
        end else begin
            seen = 1'b0;
        end
    end

    task automatic set_op(input int i, input logic [31:0] a,
                          input logic [31:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic wait_grants(input int target, input string name);
        int k = 0;
        while (n_grants < target && k < 60) begin
            @(negedge clk); #1;
            k++;
        end
        chk(name, 32'(n_grants), 32'(target));
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || bus.resp_valid || busy) && k < 80) begin
            @(negedge clk); #1;
            k++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_one(input logic [3:0] mask, input int gid,
                           input logic [31:0] a, input logic [31:0] b,
                           input resp_t e, input string name);
        int base;
        @(posedge clk); #1;
        set_op(gid, a, b);
        gnt_q.push_back(gid);
        exp_q.push_back(e);
        bus.resp_ready = 1'b1;
        base = n_grants;
        bus.req_valid = mask;
        wait_grants(base + 1, {name, "_grant"});
        @(posedge clk); #1 bus.req_valid = '0;
        drain({name, "_drain"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        int rv_seen;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
        chk("rst_carry", 32'(bus.resp_carry), 32'd0);
        chk("rst_ovf", 32'(bus.resp_ovf), 32'd0);
        chk("rst_ops", 32'(ops_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: single request
        run_one(4'b0001, 0, 32'd2, 32'd3,
                resp_t'{2'd0, 32'd5, 1'b0, 1'b0}, "t1");
        chk("t1_ops", 32'(ops_done), 32'd1);
        reset_dut();

        // 2: all four held, grants 0,1,2,3,0
        @(posedge clk); #1;
        set_op(0, 32'd1, 32'd2);
        set_op(1, 32'h10, 32'h20);
        set_op(2, 32'h8000_0000, 32'h8000_0000);
        set_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        gnt_q.push_back(0); exp_q.push_back(resp_t'{2'd0, 32'd3, 1'b0, 1'b0});
        gnt_q.push_back(1); exp_q.push_back(resp_t'{2'd1, 32'h30, 1'b0, 1'b0});
        gnt_q.push_back(2); exp_q.push_back(resp_t'{2'd2, 32'd0, 1'b1, 1'b1});
        gnt_q.push_back(3); exp_q.push_back(resp_t'{2'd3, 32'hFFFF_FFFE, 1'b1, 1'b0});
        gnt_q.push_back(0); exp_q.push_back(resp_t'{2'd0, 32'd3, 1'b0, 1'b0});
        bus.resp_ready = 1'b1;
        prev_g = -1;
        tput_on = 1'b1;
        base = n_grants;
        bus.req_valid = 4'b1111;
        wait_grants(base + 5, "t2_grants");
        @(posedge clk); #1 bus.req_valid = '0;
        drain("t2_drain");
        tput_on = 1'b0;
        chk("t2_ops", 32'(ops_done), 32'd5);

        // 3: backpressure on requester 1, others queue up
        @(posedge clk); #1;
        set_op(1, 32'd10, 32'd6);
        gnt_q.push_back(1); exp_q.push_back(resp_t'{2'd1, 32'd16, 1'b0, 1'b0});
        bus.resp_ready = 1'b0;
        base = n_grants;
        bus.req_valid = 4'b0010;
        wait_grants(base + 1, "t3_grant");
        @(posedge clk); #1 bus.req_valid = 4'b1100;
        gnt_q.push_back(2); exp_q.push_back(resp_t'{2'd2, 32'd0, 1'b1, 1'b1});
        gnt_q.push_back(3); exp_q.push_back(resp_t'{2'd3, 32'hFFFF_FFFE, 1'b1, 1'b0});
        k = 0;
        while (!bus.resp_valid && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        repeat (10) begin
            @(negedge clk); #1;
            chk("t3_valid", 32'(bus.resp_valid), 32'd1);
            chk("t3_data", bus.resp_data, 32'd16);
            chk("t3_id", 32'(bus.resp_id), 32'd1);
            chk("t3_req_ready", 32'(bus.req_ready), 32'd0);
            chk("t3_ops_hold", 32'(ops_done), 32'd5);
        end
        @(posedge clk); #1 bus.resp_ready = 1'b1;
        base = n_grants;
        wait_grants(base + 1, "t3_grant2");
        chk("t3_ops_rel", 32'(ops_done), 32'd6);
        wait_grants(base + 2, "t3_grant3");
        @(posedge clk); #1 bus.req_valid = '0;
        drain("t3_drain");

        // 4: signed overflow and unsigned carry
        run_one(4'b0001, 0, 32'h7FFF_FFFF, 32'd1,
                resp_t'{2'd0, 32'h8000_0000, 1'b0, 1'b1}, "t4a");
        run_one(4'b0001, 0, 32'hFFFF_FFFF, 32'd1,
                resp_t'{2'd0, 32'd0, 1'b1, 1'b0}, "t4b");

        // 5: reset while in EXEC
        @(posedge clk); #1;
        set_op(2, 32'd5, 32'd5);
        gnt_q.push_back(2);
        base = n_grants;
        bus.req_valid = 4'b0100;
        wait_grants(base + 1, "t5_grant");
        @(posedge clk); #1 bus.req_valid = '0;
        chk("t5_busy_exec", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("t5_rst_data", bus.resp_data, 32'd0);
        chk("t5_rst_carry", 32'(bus.resp_carry), 32'd0);
        chk("t5_rst_ops", 32'(ops_done), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rv_seen = 0;
        repeat (5) begin
            @(negedge clk); #1;
            if (bus.resp_valid) rv_seen++;
        end
        chk("t5_no_resp", 32'(rv_seen), 32'd0);
        run_one(4'b0101, 0, 32'd9, 32'd1,
                resp_t'{2'd0, 32'd10, 1'b0, 1'b0}, "t5_next");

        // 6: fairness after grant to 2, and ops_done wrap
        run_one(4'b0100, 2, 32'd1, 32'd1,
                resp_t'{2'd2, 32'd2, 1'b0, 1'b0}, "t6a");
        @(negedge clk);
        force dut.ops_q = 16'hFFFF;
        #1 release dut.ops_q;
        #1 chk("t6_preload", 32'(ops_done), 32'h0000_FFFF);
        run_one(4'b0110, 1, 32'd3, 32'd4,
                resp_t'{2'd1, 32'd7, 1'b0, 1'b0}, "t6b");
        chk("t6_ops_wrap", 32'(ops_done), 32'd0);
        chk("t6_gnt_left", 32'(gnt_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
